// File: rtl/uart_rx_monitor_if.sv
// Serial receive/monitor bundle: line input, comparison byte, counter clear,
// and the recovered byte, status pulses and counters.
interface uart_rx_monitor_if;
  logic        rx;
  logic [7:0]  expected_data;
  logic        clear_counts;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_error;
  logic        busy;
  logic [15:0] byte_count;
  logic [15:0] mismatch_count;
  logic [15:0] error_count;

  modport slave (
    input  rx, expected_data, clear_counts,
    output rx_data, rx_valid, frame_error, busy,
           byte_count, mismatch_count, error_count
  );

  modport master (
    output rx, expected_data, clear_counts,
    input  rx_data, rx_valid, frame_error, busy,
           byte_count, mismatch_count, error_count
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver with framing check, byte/mismatch/error counters,
// used as a loopback checker downstream of the UART transmitter.
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic               system_clock,
  input  logic               cpu_rst_n,
  uart_rx_monitor_if.slave   bus
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_s;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        good, bad;
  logic [7:0]  data_q;
  logic        valid_q, ferr_q;
  logic [15:0] byte_cnt, mismatch_cnt, err_cnt;

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    good    = 1'b0;
    bad     = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        idx_n   = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_n      = '0;
          shift_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          if (rx_s) begin
            good    = 1'b1;
            state_n = S_IDLE;
          end else begin
            bad     = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line goes idle so a long break cannot start a frame.
        timer_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (!cpu_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      state   <= state_n;
      timer   <= timer_n;
      idx     <= idx_n;
      shift   <= shift_n;
      valid_q <= good;
      ferr_q  <= bad;
      if (good) data_q <= shift;
    end
  end

  // Clear takes priority over any increment landing on the same edge.
  always_ff @(posedge system_clock) begin
    if (!cpu_rst_n || bus.clear_counts) begin
      byte_cnt     <= '0;
      mismatch_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      if (good) byte_cnt <= byte_cnt + 16'd1;
      if (good && (shift != bus.expected_data) && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + 16'd1;
      if (bad && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.rx_data        = data_q;
  assign bus.rx_valid       = valid_q;
  assign bus.frame_error    = ferr_q;
  assign bus.busy           = (state != S_IDLE);
  assign bus.byte_count     = byte_cnt;
  assign bus.mismatch_count = mismatch_cnt;
  assign bus.error_count    = err_cnt;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 16 clocks per bit.
module tb_uart_rx_monitor;
  localparam int unsigned C = 16;

  logic system_clock = 1'b0;
  logic cpu_rst_n    = 1'b0;
  int   cyc          = 0;
  int   errors       = 0;
  int   checks       = 0;

  int         valid_n = 0;
  int         ferr_n  = 0;
  int         last_valid_cyc = 0;
  logic [7:0] valid_q[$];

  uart_rx_monitor_if bus ();

  uart_rx_monitor #(.CLKS_PER_BIT(C), .HALF_BIT(C / 2)) dut (
    .system_clock (system_clock),
    .cpu_rst_n    (cpu_rst_n),
    .bus          (bus.slave)
  );

  always #5 system_clock = ~system_clock;
  always @(posedge system_clock) cyc <= cyc + 1;

  always @(negedge system_clock) begin
    if (bus.rx_valid) begin
      valid_n++;
      valid_q.push_back(bus.rx_data);
      last_valid_cyc = cyc;
    end
    if (bus.frame_error) ferr_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(C);
    end
    bus.rx = stop_bit;
    tick(C);
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.expected_data = 8'h00;
    bus.clear_counts = 1'b0;
    tick(3);
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got=%b want=0", bus.frame_error); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.byte_count !== 16'h0) begin errors++; $display("FAIL reset_byte_count got=%h want=0000", bus.byte_count); end
    checks++; if (bus.mismatch_count !== 16'h0) begin errors++; $display("FAIL reset_mismatch_count got=%h want=0000", bus.mismatch_count); end
    checks++; if (bus.error_count !== 16'h0) begin errors++; $display("FAIL reset_error_count got=%h want=0000", bus.error_count); end
    cpu_rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    int v0, t0;
    valid_q.delete();
    bus.expected_data = 8'hA5;
    v0 = valid_n;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(5);
    checks++; if (valid_n - v0 != 1) begin errors++; $display("FAIL single_pulses got=%0d want=1", valid_n - v0); end
    checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data got=%h want=a5", bus.rx_data); end
    checks++; if (last_valid_cyc != t0 + 155) begin errors++; $display("FAIL single_latency got=%0d want=%0d", last_valid_cyc - t0, 155); end
    checks++; if (bus.byte_count !== 16'd1) begin errors++; $display("FAIL single_byte_count got=%h want=0001", bus.byte_count); end
    checks++; if (bus.mismatch_count !== 16'd0) begin errors++; $display("FAIL single_mismatch got=%h want=0000", bus.mismatch_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b want=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want[0] = 8'h00; want[1] = 8'hFF; want[2] = 8'h3C;
    bus.clear_counts = 1'b1;
    tick(1);
    bus.clear_counts = 1'b0;
    checks++; if (bus.byte_count !== 16'd0) begin errors++; $display("FAIL clear_byte_count got=%h want=0000", bus.byte_count); end
    valid_q.delete();
    bus.expected_data = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(want[i], 1'b1);
    tick(5);
    checks++;
    if (valid_q.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d want=3", valid_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (valid_q[i] !== want[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, valid_q[i], want[i]); end
      end
    end
    checks++; if (bus.byte_count !== 16'd3) begin errors++; $display("FAIL b2b_byte_count got=%h want=0003", bus.byte_count); end
    checks++; if (bus.mismatch_count !== 16'd2) begin errors++; $display("FAIL b2b_mismatch got=%h want=0002", bus.mismatch_count); end
    checks++; if (bus.error_count !== 16'd0) begin errors++; $display("FAIL b2b_error_count got=%h want=0000", bus.error_count); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_n; f0 = ferr_n;
    bus.expected_data = 8'h55;
    send_frame(8'h55, 1'b0);
    tick(30 * C);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break got=%b want=1", bus.busy); end
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL ferr_pulses got=%0d want=1", ferr_n - f0); end
    checks++; if (valid_n != v0) begin errors++; $display("FAIL ferr_no_valid got=%0d want=0", valid_n - v0); end
    checks++; if (bus.error_count !== 16'd1) begin errors++; $display("FAIL ferr_error_count got=%h want=0001", bus.error_count); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_rx_data_held got=%h want=3c", bus.rx_data); end
    checks++; if (bus.byte_count !== 16'd3) begin errors++; $display("FAIL ferr_byte_count got=%h want=0003", bus.byte_count); end
    bus.rx = 1'b1;
    tick(4);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got=%b want=0", bus.busy); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_n; f0 = ferr_n;
    bus.rx = 1'b0;
    tick(4);
    bus.rx = 1'b1;
    tick(3);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%b want=1", bus.busy); end
    tick(20);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle got=%b want=0", bus.busy); end
    checks++; if (valid_n != v0 || ferr_n != f0) begin errors++; $display("FAIL glitch_pulses got=%0d/%0d want=0/0", valid_n - v0, ferr_n - f0); end
    checks++; if (bus.byte_count !== 16'd3 || bus.mismatch_count !== 16'd2 || bus.error_count !== 16'd1) begin
      errors++; $display("FAIL glitch_counts got=%h/%h/%h want=0003/0002/0001", bus.byte_count, bus.mismatch_count, bus.error_count);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, f0;
    bus.rx = 1'b0;
    tick(C);
    tick(4 * C);
    tick(C / 2);
    cpu_rst_n = 1'b0;
    bus.rx = 1'b1;
    tick(1);
    cpu_rst_n = 1'b1;
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL mrst_rx_data got=%h want=00", bus.rx_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.rx_valid !== 1'b0 || bus.frame_error !== 1'b0) begin errors++; $display("FAIL mrst_pulses got=%b%b want=00", bus.rx_valid, bus.frame_error); end
    checks++; if (bus.byte_count !== 16'd0 || bus.mismatch_count !== 16'd0 || bus.error_count !== 16'd0) begin
      errors++; $display("FAIL mrst_counts got=%h/%h/%h want=0000/0000/0000", bus.byte_count, bus.mismatch_count, bus.error_count);
    end
    v0 = valid_n; f0 = ferr_n;
    tick(20);
    valid_q.delete();
    bus.expected_data = 8'h81;
    send_frame(8'h81, 1'b1);
    tick(5);
    checks++; if (valid_n - v0 != 1 || ferr_n != f0) begin errors++; $display("FAIL mrst_pulses_after got=%0d/%0d want=1/0", valid_n - v0, ferr_n - f0); end
    checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL mrst_rx_data_after got=%h want=81", bus.rx_data); end
    checks++; if (bus.byte_count !== 16'd1) begin errors++; $display("FAIL mrst_byte_count got=%h want=0001", bus.byte_count); end
    checks++; if (bus.mismatch_count !== 16'd0) begin errors++; $display("FAIL mrst_mismatch got=%h want=0000", bus.mismatch_count); end
  endtask

  task automatic test_wrap_saturate();
    int f0;
    force dut.byte_cnt = 16'hFFFF;
    force dut.mismatch_cnt = 16'hFFFF;
    force dut.err_cnt = 16'hFFFF;
    tick(1);
    release dut.byte_cnt;
    release dut.mismatch_cnt;
    release dut.err_cnt;
    tick(1);
    bus.expected_data = 8'h00;
    send_frame(8'h7E, 1'b1);
    tick(5);
    checks++; if (bus.byte_count !== 16'h0000) begin errors++; $display("FAIL wrap_byte_count got=%h want=0000", bus.byte_count); end
    checks++; if (bus.mismatch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_mismatch got=%h want=ffff", bus.mismatch_count); end
    checks++; if (bus.rx_data !== 8'h7E) begin errors++; $display("FAIL wrap_rx_data got=%h want=7e", bus.rx_data); end
    f0 = ferr_n;
    send_frame(8'h11, 1'b0);
    tick(C);
    bus.rx = 1'b1;
    tick(5);
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL sat_ferr_pulse got=%0d want=1", ferr_n - f0); end
    checks++; if (bus.error_count !== 16'hFFFF) begin errors++; $display("FAIL sat_error_count got=%h want=ffff", bus.error_count); end
    checks++; if (bus.byte_count !== 16'h0000) begin errors++; $display("FAIL sat_byte_count got=%h want=0000", bus.byte_count); end
  endtask

  task automatic test_clear_coincident();
    int v0, t0;
    v0 = valid_n;
    t0 = cyc;
    bus.expected_data = 8'h00;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(154);
        bus.clear_counts = 1'b1;
        tick(1);
        bus.clear_counts = 1'b0;
      end
    join
    tick(3);
    checks++; if (valid_n - v0 != 1 || last_valid_cyc != t0 + 155) begin
      errors++; $display("FAIL clr_valid got=%0d@%0d want=1@155", valid_n - v0, last_valid_cyc - t0);
    end
    checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL clr_rx_data got=%h want=5a", bus.rx_data); end
    checks++; if (bus.byte_count !== 16'd0 || bus.mismatch_count !== 16'd0 || bus.error_count !== 16'd0) begin
      errors++; $display("FAIL clr_counts got=%h/%h/%h want=0000/0000/0000", bus.byte_count, bus.mismatch_count, bus.error_count);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.expected_data = 8'h00;
    bus.clear_counts = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_wrap_saturate();
    test_clear_coincident();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
